// File: rtl/fetch_sequencer_pkg.sv
// Shared types and defaults for the fetch sequencer slice: FSM state
// encoding, next-PC select encoding and the default datapath widths.
package fetch_sequencer_pkg;

   localparam int ADDR_W_DEF  = 32;
   localparam int INSTR_W_DEF = 32;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FETCH   = 3'd1,
      ST_DELIVER = 3'd2,
      ST_RESOLVE = 3'd3,
      ST_HALTED  = 3'd4
   } fseq_state_t;

   // HOLD means the PC keeps its value (pc_halt stays high).
   typedef enum logic [1:0] {
      NPC_SEQ  = 2'd0,
      NPC_BR   = 2'd1,
      NPC_JMP  = 2'd2,
      NPC_HOLD = 2'd3
   } npc_sel_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bundle of the PC, instruction-memory and decode/execute signals seen by
// the fetch sequencer. master = sequencer side, slave = surrounding core.
interface fetch_sequencer_if #(
   parameter int ADDR_W  = 32,
   parameter int INSTR_W = 32
);
   logic [ADDR_W-1:0]  pc_cur;
   logic [ADDR_W-1:0]  pc_next;
   logic               pc_halt;
   logic               imem_req;
   logic               imem_ack;
   logic [INSTR_W-1:0] imem_rdata;
   logic [INSTR_W-1:0] instr;
   logic               instr_valid;
   logic               dec_ready;
   logic               resolve_valid;
   logic               br_taken;
   logic [ADDR_W-1:0]  br_target;
   logic               jmp;
   logic [ADDR_W-1:0]  jmp_target;
   logic               halt_req;
   logic               halted;
   logic [31:0]        retire_count;

   modport master (
      input  pc_cur, imem_ack, imem_rdata, dec_ready, resolve_valid,
             br_taken, br_target, jmp, jmp_target, halt_req,
      output pc_next, pc_halt, imem_req, instr, instr_valid, halted,
             retire_count
   );

   modport slave (
      output pc_cur, imem_ack, imem_rdata, dec_ready, resolve_valid,
             br_taken, br_target, jmp, jmp_target, halt_req,
      input  pc_next, pc_halt, imem_req, instr, instr_valid, halted,
             retire_count
   );
endinterface

// File: rtl/fetch_sequencer_next_pc_mux.sv
// Combinational next-PC selector. HOLD still produces pc_cur + 1 so the
// PC input never floats to an arbitrary value while the PC is frozen.
module next_pc_mux
   import fetch_sequencer_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  npc_sel_t            sel,
   input  logic [ADDR_W-1:0]   pc_cur,
   input  logic [ADDR_W-1:0]   br_target,
   input  logic [ADDR_W-1:0]   jmp_target,
   output logic [ADDR_W-1:0]   pc_next
);
   logic [ADDR_W-1:0] pc_inc_s;

   // Word-addressed increment; wraps naturally at the top of the space.
   assign pc_inc_s = pc_cur + {{(ADDR_W-1){1'b0}}, 1'b1};

   // Pick the PC source requested by the sequencer.
   always_comb begin
      pc_next = pc_inc_s;
      case (sel)
         NPC_SEQ:  pc_next = pc_inc_s;
         NPC_BR:   pc_next = br_target;
         NPC_JMP:  pc_next = jmp_target;
         NPC_HOLD: pc_next = pc_inc_s;
         default:  pc_next = pc_inc_s;
      endcase
   end
endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch controller: fetches one instruction, hands it to
// decode, waits for execute to resolve it, then lets the PC load exactly
// once with the selected next address. HALT freezes the core until reset.
module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int INSTR_W = INSTR_W_DEF
) (
   input logic               clk,
   input logic               reset,
   fetch_sequencer_if.master bus
);
   fseq_state_t        state_r;
   logic               imem_req_r;
   logic               instr_valid_r;
   logic [INSTR_W-1:0] instr_r;
   logic               halted_r;
   logic [31:0]        retire_count_r;
   npc_sel_t           npc_sel_s;
   logic [ADDR_W-1:0]  pc_next_s;

   // Next-PC select: only a resolution seen in RESOLVE releases the PC;
   // halt beats jump, jump beats branch, branch beats sequential.
   always_comb begin
      npc_sel_s = NPC_HOLD;
      if ((state_r == ST_RESOLVE) && bus.resolve_valid) begin
         if (bus.halt_req) begin
            npc_sel_s = NPC_HOLD;
         end else if (bus.jmp) begin
            npc_sel_s = NPC_JMP;
         end else if (bus.br_taken) begin
            npc_sel_s = NPC_BR;
         end else begin
            npc_sel_s = NPC_SEQ;
         end
      end else begin
         npc_sel_s = NPC_HOLD;
      end
   end

   next_pc_mux #(.ADDR_W(ADDR_W)) u_next_pc_mux (
      .sel        (npc_sel_s),
      .pc_cur     (bus.pc_cur),
      .br_target  (bus.br_target),
      .jmp_target (bus.jmp_target),
      .pc_next    (pc_next_s)
   );

   // Sequencer FSM with registered request/valid/halted outputs, the
   // instruction latch and the retire counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r        <= ST_IDLE;
         imem_req_r     <= 1'b0;
         instr_valid_r  <= 1'b0;
         instr_r        <= {INSTR_W{1'b0}};
         halted_r       <= 1'b0;
         retire_count_r <= 32'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               state_r    <= ST_FETCH;
               imem_req_r <= 1'b1;
            end
            ST_FETCH: begin
               if (bus.imem_ack) begin
                  instr_r       <= bus.imem_rdata;
                  imem_req_r    <= 1'b0;
                  instr_valid_r <= 1'b1;
                  state_r       <= ST_DELIVER;
               end
            end
            ST_DELIVER: begin
               if (bus.dec_ready) begin
                  instr_valid_r <= 1'b0;
                  state_r       <= ST_RESOLVE;
               end
            end
            ST_RESOLVE: begin
               if (bus.resolve_valid) begin
                  if (bus.halt_req) begin
                     halted_r <= 1'b1;
                     state_r  <= ST_HALTED;
                  end else begin
                     retire_count_r <= retire_count_r + 32'd1;
                     imem_req_r     <= 1'b1;
                     state_r        <= ST_FETCH;
                  end
               end
            end
            ST_HALTED: begin
               state_r <= ST_HALTED;
            end
            default: begin
               state_r       <= ST_IDLE;
               imem_req_r    <= 1'b0;
               instr_valid_r <= 1'b0;
               halted_r      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.pc_next      = pc_next_s;
   assign bus.pc_halt      = (npc_sel_s == NPC_HOLD);
   assign bus.imem_req     = imem_req_r;
   assign bus.instr        = instr_r;
   assign bus.instr_valid  = instr_valid_r;
   assign bus.halted       = halted_r;
   assign bus.retire_count = retire_count_r;
endmodule
